// File: rtl/fifo_arbiter_n_if.sv
// fifo_arbiter_n bus: producer push ports plus the downstream FIFO write port.
// The slave view belongs to the arbiter. The master view belongs to whoever drives it.
interface fifo_arbiter_n_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic [CHANNELS*WIDTH-1:0] wrdata;
  logic [CHANNELS-1:0]       push;
  logic [CHANNELS-1:0]       ready;
  logic                      full_in;
  logic [WIDTH-1:0]          wrdata_out;
  logic                      push_out;
  logic [CHANNELS-1:0]       grant;
  logic                      overflow;

  modport slave (
    input  wrdata,
    input  push,
    input  full_in,
    output ready,
    output wrdata_out,
    output push_out,
    output grant,
    output overflow
  );

  modport master (
    output wrdata,
    output push,
    output full_in,
    input  ready,
    input  wrdata_out,
    input  push_out,
    input  grant,
    input  overflow
  );
endinterface

// File: rtl/fifo_arbiter_n.sv
// N-channel write arbiter. Each channel has a small private ring buffer.
// The arbiter merges the channels into one downstream FIFO write port.
module fifo_arbiter_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 2,
  parameter int RR       = 1
) (
  input logic             clk,
  input logic             rst,
  fifo_arbiter_n_if.slave bus
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;
  localparam int IW = $clog2(CHANNELS);

  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_CH  = IW'(CHANNELS - 1);

  logic [WIDTH-1:0] mem [CHANNELS][DEPTH];

  logic [PW-1:0] wr_ptr [CHANNELS];
  logic [PW-1:0] rd_ptr [CHANNELS];
  logic [PW-1:0] cnt    [CHANNELS];

  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] rdy;
  logic [CHANNELS-1:0] wr_en;
  logic [CHANNELS-1:0] rd_en;
  logic [CHANNELS-1:0] drop;

  logic [IW-1:0] last_grant;
  logic [IW-1:0] sel;
  logic [IW-1:0] out_ch;
  logic          found;
  logic          issue;
  logic          ovf;

  function automatic logic [PW-1:0] inc_ptr(
    input logic [PW-1:0] p
  );
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Per-channel status is derived from the registered count only.
  // Ready therefore ignores a pop that happens in the same cycle.
  always_comb begin
    req   = '0;
    rdy   = '0;
    wr_en = '0;
    drop  = '0;
    rd_en = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      req[i]   = (cnt[i] != '0);
      rdy[i]   = (cnt[i] < FULL_CNT);
      wr_en[i] = bus.push[i] & rdy[i];
      drop[i]  = bus.push[i] & ~rdy[i];
      rd_en[i] = issue && (sel == IW'(i));
    end
  end

  // Pick the winning channel.
  // Fixed mode scans upward from 0.
  // Round-robin scans upward from the channel after the last one issued.
  always_comb begin
    int idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (RR != 0)
        idx = (int'(last_grant) + 1 + k) % CHANNELS;
      else
        idx = k;
      if (!found && req[idx]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end
    end
  end

  // Drive the output port combinationally from registered state.
  // A high full_in blocks the issue in the same cycle.
  always_comb begin
    issue          = (|req) & ~bus.full_in;
    out_ch         = issue ? sel : '0;
    bus.push_out   = issue;
    bus.grant      = issue ? (CHANNELS'(1) << sel) : '0;
    bus.wrdata_out = mem[out_ch][rd_ptr[out_ch][AW-1:0]];
    bus.ready      = rdy;
    bus.overflow   = ovf;
  end

  // Buffer storage needs no reset, because the counts mark which entries are valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rst && wr_en[i])
        mem[i][wr_ptr[i][AW-1:0]] <= bus.wrdata[i*WIDTH +: WIDTH];
    end
  end

  // Update the pointers, counts, sticky overflow and round-robin state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      last_grant <= LAST_CH;
      ovf        <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en[i])
          wr_ptr[i] <= inc_ptr(wr_ptr[i]);
        if (rd_en[i])
          rd_ptr[i] <= inc_ptr(rd_ptr[i]);
        case ({wr_en[i], rd_en[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
      if (|drop)
        ovf <= 1'b1;
      if (issue)
        last_grant <= sel;
    end
  end

endmodule

// File: tb/tb_fifo_arbiter_n.sv
// Directed bench for fifo_arbiter_n.
// One instance uses fixed priority and one uses round-robin, with the same stimulus on both.
module tb_fifo_arbiter_n;

  localparam int W = 8;
  localparam int C = 4;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_arbiter_n_if #(.WIDTH(W), .CHANNELS(C)) b0 ();
  fifo_arbiter_n_if #(.WIDTH(W), .CHANNELS(C)) b1 ();

  fifo_arbiter_n #(
    .WIDTH(W), .CHANNELS(C), .DEPTH(D), .RR(0)
  ) u_fix (
    .clk(clk), .rst(rst), .bus(b0)
  );

  fifo_arbiter_n #(
    .WIDTH(W), .CHANNELS(C), .DEPTH(D), .RR(1)
  ) u_rr (
    .clk(clk), .rst(rst), .bus(b1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [C-1:0]   p,
    input logic [C*W-1:0] d
  );
    b0.push   = p;
    b1.push   = p;
    b0.wrdata = d;
    b1.wrdata = d;
  endtask

  task automatic set_full(input logic f);
    b0.full_in = f;
    b1.full_in = f;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive('0, '0);
    set_full(1'b0);
    step;
    step;
    rst = 1'b0;
  endtask

  initial begin
    logic [C*W-1:0] d;

    // Check the reset state.
    do_reset;
    #1;
    chk("rst_push_out", b0.push_out, 0);
    chk("rst_grant",    b1.grant, 0);
    chk("rst_ready",    b0.ready, 4'hf);
    chk("rst_ovf",      b1.overflow, 0);

    // A single word on channel 2 appears one cycle later.
    drive(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
    step;
    drive('0, '0);
    #1;
    chk("one_push_out", b0.push_out, 1);
    chk("one_data",     b0.wrdata_out, 8'hA5);
    chk("one_grant",    b0.grant, 4'b0100);
    chk("one_grant_rr", b1.grant, 4'b0100);
    step;
    chk("one_idle", b0.push_out, 0);

    // All channels push at once. Fixed priority issues 0..3.
    // Round-robin resumes after channel 2.
    drive(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10});
    step;
    drive('0, '0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fix_data",  b0.wrdata_out, 8'h10 + k);
      chk("fix_grant", b0.grant, 1 << k);
      chk("rr_resume", b1.grant, 1 << ((3 + k) % 4));
      step;
    end
    chk("fix_drained", b0.push_out, 0);

    // Round-robin with every channel pushing whenever it is ready.
    do_reset;
    for (int t = 0; t < 8; t++) begin
      d = '0;
      for (int i = 0; i < C; i++)
        d[i*W +: W] = {4'(i), 4'(t)};
      drive(b1.ready, d);
      step;
      chk("rr_grant", b1.grant, 1 << (t % 4));
      chk("rr_src",   b1.wrdata_out[7:4], t % 4);
    end

    // Channel 3 issues alone. Channels 0 and 3 then compete, and channel 0 wins.
    do_reset;
    drive(4'b1000, {8'h31, 24'h0});
    step;
    chk("wrap_g3", b1.grant, 4'b1000);
    drive(4'b1001, {8'h32, 16'h0, 8'h02});
    step;
    drive('0, '0);
    #1;
    chk("wrap_g0",  b1.grant, 4'b0001);
    chk("wrap_d0",  b1.wrdata_out, 8'h02);
    step;
    chk("wrap_g3b", b1.grant, 4'b1000);
    chk("wrap_d3",  b1.wrdata_out, 8'h32);

    // Backpressure: channel 1 fills to DEPTH and its third word is dropped.
    do_reset;
    set_full(1'b1);
    drive(4'b0010, {16'h0, 8'hB0, 8'h0});
    step;
    chk("bp_rdy1", b0.ready[1], 1);
    drive(4'b0010, {16'h0, 8'hB1, 8'h0});
    step;
    chk("bp_rdy0",  b0.ready[1], 0);
    chk("bp_stall", b0.push_out, 0);
    drive(4'b0010, {16'h0, 8'hB2, 8'h0});
    step;
    chk("bp_ovf", b0.overflow, 1);
    drive('0, '0);
    set_full(1'b0);
    #1;
    chk("bp_d0", b0.wrdata_out, 8'hB0);
    chk("bp_p0", b0.push_out, 1);
    step;
    chk("bp_d1", b0.wrdata_out, 8'hB1);
    step;
    chk("bp_end", b0.push_out, 0);

    // A full channel drops a push made in the same cycle as a pop.
    do_reset;
    set_full(1'b1);
    drive(4'b0001, {24'h0, 8'hA0});
    step;
    drive(4'b0001, {24'h0, 8'hA1});
    step;
    set_full(1'b0);
    drive(4'b0001, {24'h0, 8'hA2});
    #1;
    chk("fp_rdy", b0.ready[0], 0);
    chk("fp_d0",  b0.wrdata_out, 8'hA0);
    step;
    drive('0, '0);
    #1;
    chk("fp_ovf",  b0.overflow, 1);
    chk("fp_rdy1", b0.ready[0], 1);
    chk("fp_d1",   b0.wrdata_out, 8'hA1);
    step;
    chk("fp_end", b0.push_out, 0);

    // Reset in the middle of traffic, with a push during the reset cycle.
    do_reset;
    set_full(1'b1);
    drive(4'b0111, {8'h0, 8'h22, 8'h21, 8'h20});
    step;
    step;
    step;
    drive('0, '0);
    chk("mr_ovf_set", b0.overflow, 1);
    rst = 1'b1;
    set_full(1'b0);
    drive(4'b1000, {8'h3F, 24'h0});
    step;
    rst = 1'b0;
    drive('0, '0);
    #1;
    chk("mr_push_out", b0.push_out, 0);
    chk("mr_ready",    b1.ready, 4'hf);
    chk("mr_ovf",      b0.overflow, 0);
    drive(4'b0010, {16'h0, 8'h5C, 8'h0});
    #1;
    chk("mr_nobypass", b0.push_out, 0);
    step;
    drive('0, '0);
    #1;
    chk("mr_p",     b0.push_out, 1);
    chk("mr_data",  b0.wrdata_out, 8'h5C);
    chk("mr_grant", b1.grant, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_arbiter_n.md
# fifo_arbiter_n

Parametrised N-channel write arbiter that merges push streams from several producers into the single write port of one downstream FIFO. Each channel owns a small private buffer, so simultaneous pushes are never lost while there is space. Each channel reports its free space upstream, and the block honours a full signal from the downstream FIFO. It replaces the two-input, one-entry arbiter wherever more than two producers share a FIFO, or where the sink can stall.

## Interface
- WIDTH, 8, data word width in bits
- CHANNELS, 4, number of producer channels (2..16)
- DEPTH, 2, entries per channel buffer (power of two, 2..16)
- RR, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wrdata  in  CHANNELS*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
- push  in  CHANNELS  channel i write strobe, one word per cycle
- ready  out  CHANNELS  channel i buffer has at least one free entry
- full_in  in  1  downstream FIFO full; no word issued while high
- wrdata_out  out  WIDTH  word presented to downstream FIFO
- push_out  out  1  downstream write strobe
- grant  out  CHANNELS  one-hot source of the current wrdata_out; zero when push_out is low
- overflow  out  1  sticky: a push arrived on a channel with ready low

## Operation
- Per-channel circular buffer with write pointer, read pointer and count, each log2(DEPTH)+1 bits wide. Pointers wrap modulo DEPTH.
- ready[i] = (count_i < DEPTH). It depends only on registered count; the same-cycle pop does not affect it.
- Write: push[i] & ready[i] stores wrdata[i] at wr_ptr_i, and wr_ptr_i increments.
- Dropped write: push[i] & !ready[i] discards the word and sets overflow to 1. overflow holds until rst.
- Request: req[i] = (count_i != 0).
- Issue condition: any req and !full_in. When it holds:
  - push_out = 1 and grant = the selected channel;
  - wrdata_out = head of the selected buffer;
  - the selected buffer pops.
- Output path is combinational from registered state; full_in gates push_out combinationally.
- Selection, RR=0: lowest-index requesting channel.
- Selection, RR=1:
  - search starts at last_grant+1 and runs upward modulo CHANNELS;
  - last_grant updates to the issued channel only on cycles with push_out = 1;
  - a stalled cycle (full_in = 1) leaves last_grant unchanged.
- Same-channel push and pop in one cycle (count < DEPTH): count is unchanged, both pointers advance.
- When push_out = 0, wrdata_out is don't-care; the block drives the channel-0 head.

## Timing
- Reset state:
  - all counts and pointers 0, so ready = all ones;
  - push_out 0, grant 0, overflow 0;
  - last_grant = CHANNELS-1, so channel 0 is first under RR.
- rst asserted mid-operation discards all buffered words at that edge. Pushes in the reset cycle are ignored, and overflow does not set.
- Latency:
  - a push at cycle t appears on push_out at t+1 at the earliest;
  - there is no bypass path.
- Throughput: one word per cycle total. Each channel sustains one word per cycle only when it is the sole requester.
- Full-channel boundary: with count = DEPTH, a push in the same cycle as a pop is dropped, because ready was low. Producers must sample ready before pushing.
- full_in high for any number of cycles:
  - no pop occurs and buffer contents persist;
  - pushes continue until each channel fills.
- Order within a channel is FIFO. Order across channels follows the arbitration mode.

## Test plan
- Single word: push[2]=1 with 0xA5 at cycle 0 (CHANNELS=4) -> cycle 1: push_out=1, wrdata_out=0xA5, grant=4'b0100; cycle 2: push_out=0.
- Fixed priority (RR=0): all four channels push data 0x10..0x13 in one cycle -> output order 0x10, 0x11, 0x12, 0x13 on consecutive cycles 1-4.
- Round-robin (RR=1): all channels push every cycle for 8 cycles -> grants 0,1,2,3,0,1,2,3.
  - Also check: channel 3 alone issues, then channels 0 and 3 request together -> channel 0 is granted first (pointer wrap).
- Backpressure (DEPTH=2): full_in=1, channel 1 pushes 3 words -> ready[1] falls after 2 words, third word dropped, overflow=1.
  - Release full_in -> only the first 2 words emerge, in order.
- Full plus simultaneous pop: fill channel 0 to DEPTH, full_in=0, push again in the same cycle as the pop -> word dropped, overflow=1, count becomes DEPTH-1.
- Reset mid-stream: 3 channels holding data, assert rst for 1 cycle -> next cycle push_out=0, ready=all ones, overflow=0.
  - First push after reset appears exactly 1 cycle later.
